encoded_memory_ctrl: RTL and testbench

Parametrised successor of the 8×8 encoded difference memory. The block stores, per address, the absolute difference between an input word and a fixed per-index mask, together with a sign bit and a valid bit. Reads can return either the stored difference or the fully decoded original word. A valid/ready command port, a one-cycle registered response, a multi-cycle CLEAR sweep and an occupancy counter make it a drop-in storage element for the lab datapaths.

---
 rtl/encoded_memory_pkg.sv | 30 +++
 rtl/encoded_mask_rom.sv | 32 +++
 rtl/encoded_memory_ctrl.sv | 168 ++++++++++++++++
 tb/tb_encoded_memory_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoded_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoded_memory_pkg
//  Description : Shared types and constants for the encoded difference memory:
//                command opcodes, controller states and the base mask pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package encoded_memory_pkg;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_DECODE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    // Controller states; the sweep is the only multi-cycle activity
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Base byte pattern, element k is the mask byte for index k mod 8
    localparam logic [7:0][7:0] c_mask_pattern = {
        8'hFF, 8'hF0, 8'h0F, 8'hCC, 8'h33, 8'hAA, 8'h55, 8'h00
    };

endpackage : encoded_memory_pkg
`default_nettype wire

// File: rtl/encoded_mask_rom.sv
`default_nettype none
// ============================================================================
//  Module      : encoded_mask_rom
//  Description : Combinational per-index mask: the base byte pattern selected
//                by index mod 8, replicated across the DATA_W-bit word.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoded_mask_rom
    import encoded_memory_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] index,
    output logic [DATA_W-1:0] mask
);

    localparam int c_bytes = DATA_W / 8;

    // Only the low three index bits pick the pattern byte
    logic [2:0] w_pat_sel;
    assign w_pat_sel = 3'(index);

    genvar gi;
    generate
        for (gi = 0; gi < c_bytes; gi++) begin : g_replicate
            assign mask[gi*8 +: 8] = c_mask_pattern[w_pat_sel];
        end
    endgenerate

endmodule : encoded_mask_rom
`default_nettype wire

// File: rtl/encoded_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : encoded_memory_ctrl
//  Description : Encoded difference memory with valid/ready command port,
//                registered one-cycle responses, a DEPTH-cycle CLEAR sweep
//                and an occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoded_memory_ctrl
    import encoded_memory_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              busy,
    output logic [ADDR_W:0]   count
);

    // Entry count is tied to the address width and is not a free parameter
    localparam int DEPTH = 2 ** ADDR_W;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic                w_clr_last;

    logic [DATA_W-1:0]   r_diff [DEPTH];
    logic [DEPTH-1:0]    r_sign;
    logic [DEPTH-1:0]    r_valid;

    op_t                 w_op;
    logic                w_accept;
    logic                w_do_write;
    logic                w_do_read;
    logic                w_do_decode;
    logic                w_start_clear;
    logic                w_sweep;

    logic [DATA_W-1:0]   w_mask;
    logic                w_gt;
    logic [DATA_W-1:0]   w_enc_diff;
    logic [DATA_W-1:0]   w_dec_word;
    logic [DATA_W-1:0]   w_rsp_word;

    // One mask lookup serves both the encode and decode paths, since only
    // one command is handled per cycle and the sweep needs no mask
    encoded_mask_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mask_rom (
        .index (cmd_addr),
        .mask  (w_mask)
    );

    assign w_op     = op_t'(cmd_op);
    assign w_accept = cmd_valid & cmd_ready;

    // Encode: magnitude of the difference, sign set when data exceeds mask
    assign w_gt       = (cmd_data > w_mask);
    assign w_enc_diff = w_gt ? (cmd_data - w_mask) : (w_mask - cmd_data);

    // Decode: the stored magnitude applied back onto the mask
    assign w_dec_word = r_sign[cmd_addr] ? (w_mask + r_diff[cmd_addr])
                                         : (w_mask - r_diff[cmd_addr]);

    assign w_rsp_word = !r_valid[cmd_addr] ? '0
                      : (w_op == OP_DECODE) ? w_dec_word : r_diff[cmd_addr];

    assign w_clr_last = (r_clr_idx == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: enter the sweep on an accepted CLEAR, leave after the last entry
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && (w_op == OP_CLEAR)) w_next_state = ST_CLEAR;
            ST_CLEAR: if (w_clr_last)                     w_next_state = ST_IDLE;
            default:                                      w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: ready comes straight from the state flop, never from cmd_valid
    always_comb begin
        cmd_ready     = (r_state == ST_IDLE);
        busy          = (r_state != ST_IDLE);
        w_sweep       = (r_state == ST_CLEAR);
        w_do_write    = w_accept && (w_op == OP_WRITE);
        w_do_read     = w_accept && (w_op == OP_READ);
        w_do_decode   = w_accept && (w_op == OP_DECODE);
        w_start_clear = w_accept && (w_op == OP_CLEAR);
    end

    // Sweep pointer: restarts at entry 0 on every accepted CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_idx <= '0;
        end else if (w_start_clear) begin
            r_clr_idx <= '0;
        end else if (w_sweep) begin
            r_clr_idx <= r_clr_idx + ADDR_W'(1);
        end
    end

    // Entry storage: written by WRITE, zeroed one entry per cycle by the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_diff[i] <= '0;
            end
            r_sign  <= '0;
            r_valid <= '0;
        end else if (w_do_write) begin
            r_diff[cmd_addr]  <= w_enc_diff;
            r_sign[cmd_addr]  <= w_gt;
            r_valid[cmd_addr] <= 1'b1;
        end else if (w_sweep) begin
            r_diff[r_clr_idx]  <= '0;
            r_sign[r_clr_idx]  <= 1'b0;
            r_valid[r_clr_idx] <= 1'b0;
        end
    end

    // Occupancy: up on a write to an empty entry, down on each valid entry swept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (w_do_write && !r_valid[cmd_addr]) begin
            count <= count + (ADDR_W + 1)'(1);
        end else if (w_sweep && r_valid[r_clr_idx]) begin
            count <= count - (ADDR_W + 1)'(1);
        end
    end

    // Response: strobe for one cycle, data and hit held until the next READ/DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
        end else begin
            rsp_valid <= w_do_read | w_do_decode;
            if (w_do_read || w_do_decode) begin
                rsp_data <= w_rsp_word;
                rsp_hit  <= r_valid[cmd_addr];
            end
        end
    end

endmodule : encoded_memory_ctrl
`default_nettype wire

// File: tb/tb_encoded_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoded_memory_ctrl
//  Description : Self-checking bench for encoded_memory_ctrl (8-bit default
//                instance plus a 16-bit/16-entry instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoded_memory_ctrl;
    import encoded_memory_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_hit;
    logic        busy;
    logic [3:0]  count;

    logic        w16_valid;
    logic        w16_ready;
    logic [1:0]  w16_op;
    logic [3:0]  w16_addr;
    logic [15:0] w16_data;
    logic        w16_rsp_valid;
    logic [15:0] w16_rsp_data;
    logic        w16_rsp_hit;
    logic        w16_busy;
    logic [4:0]  w16_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: original words kept per entry, encoding derived on demand
    logic [7:0] m_val   [8];
    logic       m_valid [8];
    logic [7:0] e_data;
    logic       e_hit;
    logic [7:0] pat [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};

    encoded_memory_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_hit   (rsp_hit),
        .busy      (busy),
        .count     (count)
    );

    encoded_memory_ctrl #(.DATA_W(16), .ADDR_W(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (w16_valid),
        .cmd_ready (w16_ready),
        .cmd_op    (w16_op),
        .cmd_addr  (w16_addr),
        .cmd_data  (w16_data),
        .rsp_valid (w16_rsp_valid),
        .rsp_data  (w16_rsp_data),
        .rsp_hit   (w16_rsp_hit),
        .busy      (w16_busy),
        .count     (w16_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] absd(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [31:0] valid_from(input int k);
        int n = 0;
        for (int j = k; j < 8; j++) n += (m_valid[j] ? 1 : 0);
        return 32'(n);
    endfunction

    task automatic model_clear();
        for (int j = 0; j < 8; j++) begin
            m_valid[j] = 1'b0;
            m_val[j]   = 8'h00;
        end
    endtask

    // Issue one command (leaves cmd_valid high for back-to-back use) and
    // check the response and occupancy on the following negedge
    task automatic do_op(input logic [1:0] op, input int a, input logic [7:0] d, input string tag);
        logic is_rd;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = 3'(a);
        cmd_data  = d;
        is_rd     = (op == OP_READ) || (op == OP_DECODE);
        @(posedge clk);
        if (op == OP_WRITE) begin
            m_val[a]   = d;
            m_valid[a] = 1'b1;
        end else if (is_rd) begin
            e_hit  = m_valid[a];
            e_data = !m_valid[a] ? 8'h00
                   : (op == OP_READ) ? absd(m_val[a], pat[a % 8]) : m_val[a];
        end
        @(negedge clk);
        check($sformatf("%s/rsp_valid", tag), 32'(rsp_valid), 32'(is_rd));
        check($sformatf("%s/rsp_data", tag), 32'(rsp_data), 32'(e_data));
        check($sformatf("%s/rsp_hit", tag), 32'(rsp_hit), 32'(e_hit));
        check($sformatf("%s/count", tag), 32'(count), valid_from(0));
        check($sformatf("%s/ready", tag), 32'(cmd_ready), 32'd1);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    // CLEAR sweep with a READ of entry ra held pending throughout
    task automatic clear_sweep(input int ra);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        cmd_addr  = 3'(ra);
        cmd_data  = 8'h00;
        @(posedge clk);
        #1;
        cmd_op = OP_READ;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("clr%0d/ready", k), 32'(cmd_ready), 32'd0);
            check($sformatf("clr%0d/busy", k), 32'(busy), 32'd1);
            check($sformatf("clr%0d/rsp_valid", k), 32'(rsp_valid), 32'd0);
            check($sformatf("clr%0d/count", k), 32'(count), valid_from(k));
            @(posedge clk);
        end
        model_clear();
        @(negedge clk);
        check("clr_end/ready", 32'(cmd_ready), 32'd1);
        check("clr_end/count", 32'(count), 32'd0);
        check("clr_end/rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        e_data = 8'h00;
        e_hit  = 1'b0;
        @(negedge clk);
        check("clr_held/rsp_valid", 32'(rsp_valid), 32'd1);
        check("clr_held/rsp_hit", 32'(rsp_hit), 32'd0);
        check("clr_held/rsp_data", 32'(rsp_data), 32'd0);
    endtask

    task automatic do16(input logic [1:0] op, input int a, input logic [15:0] d);
        w16_valid = 1'b1;
        w16_op    = op;
        w16_addr  = 4'(a);
        w16_data  = d;
        @(posedge clk);
        #1;
        w16_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "/busy"}, 32'(busy), 32'd0);
        check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "/rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "/rsp_hit"}, 32'(rsp_hit), 32'd0);
        check({tag, "/count"}, 32'(count), 32'd0);
        check({tag, "/count16"}, 32'(w16_count), 32'd0);
    endtask

    initial begin
        logic [1:0] rop;
        int         raddr;
        logic [7:0] rdata;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_WRITE;
        cmd_addr  = 3'd0;
        cmd_data  = 8'h00;
        w16_valid = 1'b0;
        w16_op    = OP_WRITE;
        w16_addr  = 4'd0;
        w16_data  = 16'h0000;
        model_clear();
        e_data = 8'h00;
        e_hit  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed defaults
        do_op(OP_READ, 3, 8'h00, "rd3_empty");
        do_op(OP_WRITE, 1, 8'h60, "wr1");
        check("wr1/count_lit", 32'(count), 32'd1);
        do_op(OP_READ, 1, 8'h00, "rd1");
        check("rd1/lit", 32'(rsp_data), 32'h0B);
        do_op(OP_DECODE, 1, 8'h00, "dec1");
        check("dec1/lit", 32'(rsp_data), 32'h60);
        do_op(OP_WRITE, 2, 8'h20, "wr2");
        do_op(OP_READ, 2, 8'h00, "rd2");
        check("rd2/lit", 32'(rsp_data), 32'h8A);
        do_op(OP_DECODE, 2, 8'h00, "dec2");
        check("dec2/lit", 32'(rsp_data), 32'h20);
        do_op(OP_WRITE, 2, 8'hAA, "wr2_eq");
        check("wr2_eq/count_lit", 32'(count), 32'd2);
        do_op(OP_READ, 2, 8'h00, "rd2_eq");
        check("rd2_eq/lit", 32'(rsp_data), 32'h00);
        do_op(OP_DECODE, 2, 8'h00, "dec2_eq");
        check("dec2_eq/lit", 32'(rsp_data), 32'hAA);

        // Back-to-back write/read/decode
        do_op(OP_WRITE, 7, 8'h0F, "b2b_wr");
        do_op(OP_READ, 7, 8'h00, "b2b_rd");
        check("b2b_rd/lit", 32'(rsp_data), 32'hF0);
        do_op(OP_DECODE, 7, 8'h00, "b2b_dec");
        check("b2b_dec/lit", 32'(rsp_data), 32'h0F);
        idle();

        // CLEAR with three valid entries and a held READ
        check("pre_clr/count", 32'(count), 32'd3);
        clear_sweep(1);
        for (int a = 0; a < 8; a++) do_op(OP_READ, a, 8'h00, $sformatf("post_clr_rd%0d", a));
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 120; i++) begin
            rop   = 2'($urandom_range(0, 2));
            raddr = int'($urandom_range(0, 7));
            rdata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rdata = pat[raddr];
            do_op(rop, raddr, rdata, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // 16-bit instance
        do16(OP_WRITE, 13, 16'h1234);
        do16(OP_READ, 13, 16'h0000);
        check("w16_rd13/data", 32'(w16_rsp_data), 32'h0325);
        check("w16_rd13/hit", 32'(w16_rsp_hit), 32'd1);
        do16(OP_DECODE, 13, 16'h0000);
        check("w16_dec13/data", 32'(w16_rsp_data), 32'h1234);
        do16(OP_WRITE, 0, 16'hFFFF);
        do16(OP_READ, 0, 16'h0000);
        check("w16_rd0/data", 32'(w16_rsp_data), 32'hFFFF);
        do16(OP_DECODE, 0, 16'h0000);
        check("w16_dec0/data", 32'(w16_rsp_data), 32'hFFFF);
        check("w16/count", 32'(w16_count), 32'd2);

        // Reset in the middle of a sweep
        do_op(OP_WRITE, 5, 8'h3C, "pre_rst_wr");
        do_op(OP_READ, 5, 8'h00, "pre_rst_rd");
        cmd_op    = OP_CLEAR;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_clr/busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_clr_rst");
        model_clear();
        e_data = 8'h00;
        e_hit  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst/ready", 32'(cmd_ready), 32'd1);
        for (int a = 0; a < 8; a++) do_op(OP_READ, a, 8'h00, $sformatf("post_rst_rd%0d", a));
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_encoded_memory_ctrl
`default_nettype wire
